// File: rtl/led_switch_panel.sv
// Switch/button/LED front panel: synchronises and debounces the inputs, emits press pulses,
// and drives the LEDs in latch, toggle, rotate or blink mode.
module led_switch_panel #(
  parameter int N_SW            = 4,
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int BLINK_DIV       = 5000000,
  parameter int DIV_W           = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw,
  input  logic [N_BTN-1:0] btn,
  output logic [N_SW-1:0]  led,
  output logic [1:0]       mode,
  output logic [N_BTN-1:0] btn_pulse
);

  typedef enum logic [1:0] {
    LATCH  = 2'd0,
    TOGGLE = 2'd1,
    ROTATE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  mode_t            mode_q;
  logic [N_BTN-1:0] btn_s1, btn_s2, stable, stable_q;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_SW-1:0]  sw_s1, sw_s2, pattern;
  logic [DIV_W-1:0] tick_cnt;
  logic             phase;
  logic             running;
  logic             tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Any cycle where the synchronised level matches the accepted state restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable    <= '0;
      stable_q  <= '0;
      btn_pulse <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      stable_q  <= stable;
      btn_pulse <= stable & ~stable_q;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (btn_s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= btn_s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign running = (mode_q == ROTATE) || (mode_q == BLINK);
  assign tick    = running && (tick_cnt == DIV_W'(BLINK_DIV - 1));

  // Pattern actions see the pre-edge mode, so a simultaneous mode advance
  // never changes how the same-edge load/toggle is applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern  <= '0;
      mode_q   <= LATCH;
      tick_cnt <= '0;
      phase    <= 1'b1;
    end else begin
      if (running) tick_cnt <= tick ? '0 : tick_cnt + DIV_W'(1);
      if (tick && mode_q == BLINK) phase <= ~phase;

      if (btn_pulse[0]) begin
        pattern <= (mode_q == TOGGLE) ? (pattern ^ sw_s2) : sw_s2;
      end else if (tick && mode_q == ROTATE) begin
        pattern <= {pattern[N_SW-2:0], pattern[N_SW-1]};
      end

      if (btn_pulse[1]) begin
        mode_q   <= mode_t'(mode_q + 2'd1);
        tick_cnt <= '0;
        phase    <= 1'b1;
      end
    end
  end

  assign mode = mode_q;

  always_comb begin
    led = pattern;
    if (mode_q == BLINK && !phase) led = '0;
  end

endmodule
